// File: rtl/prog_delay_line_if.sv
// Bus bundle for prog_delay_line: stream in/out, delay config and status.
//   master : drives en, cfg_we, cfg_delay, in_data, in_valid; sees status/output
//   slave  : the delay line itself
interface prog_delay_line_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic             en;
  logic             cfg_we;
  logic [DW-1:0]    cfg_delay;
  logic             cfg_err;
  logic [DW-1:0]    cur_delay;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             primed;

  modport master (
    output en, cfg_we, cfg_delay, in_data, in_valid,
    input  cfg_err, cur_delay, out_data, out_valid, primed
  );

  modport slave (
    input  en, cfg_we, cfg_delay, in_data, in_valid,
    output cfg_err, cur_delay, out_data, out_valid, primed
  );
endinterface

// File: rtl/prog_delay_line.sv
// prog_delay_line: runtime-programmable delay line for {valid, data}.
// A sample accepted on an enabled edge reappears exactly D enabled edges
// later (D = cur_delay, 0..MAX_DELAY). D=0 is a combinational passthrough.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bus.en           advance enable (0 = stall, state held)
//   bus.cfg_we       load cfg_delay (flushes stored valids, resets fill)
//   bus.cfg_delay    requested delay, clamped to MAX_DELAY
//   bus.cfg_err      one-cycle pulse after a clamped load
//   bus.cur_delay    active delay D
//   bus.in_data/in_valid    input sample
//   bus.out_data/out_valid  delayed sample, data zeroed when not valid
//   bus.primed       D enabled edges elapsed since reset/load
module prog_delay_line #(
  parameter int WIDTH       = 8,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = 5
) (
  input logic              clk,
  input logic              rst,
  prog_delay_line_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);

  logic [MAX_DELAY-1:0][WIDTH-1:0] r_data;
  logic [MAX_DELAY-1:0]            r_vld_pipe;
  logic [DW-1:0]                   r_delay;
  logic [DW-1:0]                   r_fill;
  logic                            r_cfg_err;

  logic             w_clamp;
  logic [DW-1:0]    w_new_delay;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_vld;

  assign w_clamp     = (int'(bus.cfg_delay) > MAX_DELAY);
  assign w_new_delay = w_clamp ? DW'(MAX_DELAY) : bus.cfg_delay;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_vld_pipe <= '0;
      r_delay    <= DW'(RESET_DELAY);
      r_fill     <= '0;
      r_cfg_err  <= 1'b0;
    end else if (bus.cfg_we) begin
      // Reconfigure: flush in-flight valids so nothing sampled under the old
      // delay leaks out; the input on this edge is dropped.
      r_vld_pipe <= '0;
      r_delay    <= w_new_delay;
      r_fill     <= '0;
      r_cfg_err  <= w_clamp;
    end else begin
      r_cfg_err <= 1'b0;
      if (bus.en) begin
        for (int i = MAX_DELAY - 1; i > 0; i--) begin
          r_data[i]     <= r_data[i-1];
          r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
        r_data[0]     <= bus.in_data;
        r_vld_pipe[0] <= bus.in_valid;
        if (r_fill != r_delay) r_fill <= r_fill + DW'(1);
      end
    end
  end

  // Tap select: stage D-1 holds the sample accepted D enabled edges ago.
  always_comb begin
    w_sel_data = '0;
    w_sel_vld  = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (r_delay == DW'(i + 1)) begin
        w_sel_data = r_data[i];
        w_sel_vld  = r_vld_pipe[i];
      end
    end
  end

  always_comb begin
    if (r_delay == '0) begin
      bus.out_valid = bus.in_valid;
      bus.out_data  = bus.in_valid ? bus.in_data : '0;
    end else begin
      bus.out_valid = w_sel_vld;
      bus.out_data  = w_sel_vld ? w_sel_data : '0;
    end
  end

  assign bus.cur_delay = r_delay;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.primed    = (r_fill == r_delay);
endmodule

// File: tb/tb_prog_delay_line.sv
module tb_prog_delay_line;
  localparam int WIDTH = 8;
  localparam int MAXD  = 16;
  localparam int DW    = $clog2(MAXD + 1);

  typedef struct {
    bit             rst, en, we;
    logic [DW-1:0]  cd;
    bit             iv;
    logic [7:0]     id;
    bit             eov;
    logic [7:0]     eod;
    bit             epr;
    logic [DW-1:0]  ecur;
    bit             eerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  prog_delay_line_if #(.WIDTH(WIDTH), .MAX_DELAY(MAXD)) bus ();

  prog_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .RESET_DELAY(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit e, bit w, int cd, bit iv, int id,
                              bit eov, int eod, bit epr, int ecur, bit eerr);
    vec_t v;
    v.rst = r; v.en = e; v.we = w; v.cd = DW'(cd); v.iv = iv; v.id = 8'(id);
    v.eov = eov; v.eod = 8'(eod); v.epr = epr; v.ecur = DW'(ecur); v.eerr = eerr;
    return v;
  endfunction

  task automatic check(string name, int idx, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit e, bit w, logic [DW-1:0] cd, bit iv, logic [7:0] id);
    rst = r; bus.en = e; bus.cfg_we = w; bus.cfg_delay = cd;
    bus.in_valid = iv; bus.in_data = id;
  endtask

  initial begin
    int n_en;
    bit got;
    drive(1, 0, 0, '0, 0, '0);

    // Post-reset default D=5: sample k emerges on edge k+4.
    vecs.push_back(mk(1,0,0,0,0,0,     0,0,0,5,0));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0,1,0,0,1,k, 0,0,0,5,0));
    for (int k = 5; k <= 7; k++) vecs.push_back(mk(0,1,0,0,1,k, 1,k-4,1,5,0));
    // Stall: A0 accepted, 3 stalled edges with outputs frozen, A0 after 4 more.
    vecs.push_back(mk(0,1,0,0,1,'hA0,  1,4,1,5,0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0,1,'h55, 1,4,1,5,0));
    vecs.push_back(mk(0,1,0,0,1,'h11,  1,5,1,5,0));
    vecs.push_back(mk(0,1,0,0,1,'h12,  1,6,1,5,0));
    vecs.push_back(mk(0,1,0,0,1,'h13,  1,7,1,5,0));
    vecs.push_back(mk(0,1,0,0,1,'h14,  1,'hA0,1,5,0));
    // Reconfig flush to D=2 with FF on the same edge: FF dropped.
    vecs.push_back(mk(0,1,1,2,1,'hFF,  0,0,0,2,0));
    vecs.push_back(mk(0,1,0,0,1,'h21,  0,0,0,2,0));
    vecs.push_back(mk(0,1,0,0,1,'h22,  1,'h21,1,2,0));
    vecs.push_back(mk(0,1,0,0,1,'h23,  1,'h22,1,2,0));
    // Clamp 20 -> 16, err pulse, latency 16; invalid data behind it masked.
    vecs.push_back(mk(0,1,1,20,1,'h99, 0,0,0,16,1));
    vecs.push_back(mk(0,1,0,0,1,'h40,  0,0,0,16,0));
    for (int k = 2; k <= 15; k++) vecs.push_back(mk(0,1,0,0,0,'h77, 0,0,0,16,0));
    vecs.push_back(mk(0,1,0,0,0,'h77,  1,'h40,1,16,0));
    vecs.push_back(mk(0,1,0,0,0,'h77,  0,0,1,16,0));
    // Boundary loads while stalled: 16 exact, 17 clamped, err clears while stalled.
    vecs.push_back(mk(0,0,1,16,0,0,    0,0,0,16,0));
    vecs.push_back(mk(0,0,1,17,0,0,    0,0,0,16,1));
    vecs.push_back(mk(0,0,0,0,0,0,     0,0,0,16,0));
    // D=0 passthrough.
    vecs.push_back(mk(0,1,1,0,1,'h3C,  1,'h3C,1,0,0));
    vecs.push_back(mk(0,1,0,0,0,'h3C,  0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,1,'h5A,  1,'h5A,1,0,0));
    // Reset mid-stream at D=4 (reset beats cfg_we): nothing pre-reset emerges.
    vecs.push_back(mk(0,1,1,4,1,'hEE,  0,0,0,4,0));
    for (int k = 1; k <= 3; k++) vecs.push_back(mk(0,1,0,0,1,'h60+k, 0,0,0,4,0));
    vecs.push_back(mk(1,1,1,9,1,'h64,  0,0,0,5,0));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,5,0));
    vecs.push_back(mk(0,1,0,0,0,0,     0,0,1,5,0));
    vecs.push_back(mk(0,1,0,0,0,0,     0,0,1,5,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].cd, vecs[i].iv, vecs[i].id);
      tick();
      check("out_valid", i, int'(bus.out_valid), int'(vecs[i].eov));
      check("out_data",  i, int'(bus.out_data),  int'(vecs[i].eod));
      check("primed",    i, int'(bus.primed),    int'(vecs[i].epr));
      check("cur_delay", i, int'(bus.cur_delay), int'(vecs[i].ecur));
      check("cfg_err",   i, int'(bus.cfg_err),   int'(vecs[i].eerr));
    end

    // Latency at D=3 counted in enabled edges while en toggles every cycle.
    drive(0, 1, 1, DW'(3), 0, '0);
    tick();
    drive(0, 1, 0, '0, 1, 8'hC3);
    tick();
    check("lat_first", 0, int'(bus.out_valid), 0);
    n_en = 1;
    got  = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      bus.en = (c % 2 == 1);
      tick();
      if (bus.en) n_en++;
      if (bus.out_valid) got = 1'b1;
    end
    check("lat_seen",  0, int'(got), 1);
    check("lat_edges", 0, n_en, 3);
    check("lat_data",  0, int'(bus.out_data), 'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
